state_var_sequencer: RTL and testbench

STATE_VAR_SEQUENCER -- requirements
Module: state_var_sequencer

---
 rtl/state_var_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_state_var_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/state_var_sequencer.sv
// Fetches a block of state-variable words, then sweeps a set of sub-engines one phase at a time,
// time-sharing a single operator unit between them, with a per-phase watchdog and abort.
module state_var_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_INIT_VAL  = 6,
  parameter int NUM_PHASES    = 3,
  parameter int ADDR_WIDTH    = 4,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int ITER_WIDTH    = 8
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [ITER_WIDTH-1:0]                num_iter,
  input  logic [TIMEOUT_WIDTH-1:0]             timeout_limit,
  output logic [ADDR_WIDTH-1:0]                mem_state_var_addr,
  input  logic [DATA_WIDTH-1:0]                mem_state_var_data_out,
  output logic [NUM_INIT_VAL*DATA_WIDTH-1:0]   init_val,
  output logic [NUM_PHASES-1:0]                phase_start,
  input  logic [NUM_PHASES-1:0]                phase_done,
  input  logic [NUM_PHASES*DATA_WIDTH-1:0]     client_op_a,
  input  logic [NUM_PHASES*DATA_WIDTH-1:0]     client_op_b,
  input  logic [NUM_PHASES-1:0]                client_op_start,
  output logic [DATA_WIDTH-1:0]                unit_op_a,
  output logic [DATA_WIDTH-1:0]                unit_op_b,
  output logic                                 unit_op_start,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error,
  output logic [ITER_WIDTH-1:0]                iter_count
);

  localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam int FW = $clog2(NUM_INIT_VAL + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LAUNCH, S_WAIT, S_NEXT, S_FINISH, S_FAULT
  } state_t;

  state_t                   r_state;
  logic [PW-1:0]            r_p;
  logic [FW-1:0]            r_fcnt;
  logic [TIMEOUT_WIDTH-1:0] r_wd;
  logic [TIMEOUT_WIDTH-1:0] r_tlim;
  logic [ITER_WIDTH-1:0]    r_num_iter;
  logic [ITER_WIDTH-1:0]    r_iter;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [NUM_PHASES-1:0]    r_phase_start;
  logic                     r_done;
  logic                     r_error;
  logic [DATA_WIDTH-1:0]    r_init [NUM_INIT_VAL];

  logic [DATA_WIDTH-1:0]    w_cl_a [NUM_PHASES];
  logic [DATA_WIDTH-1:0]    w_cl_b [NUM_PHASES];
  logic [PW-1:0]            w_p_inc;
  logic [FW-1:0]            w_fidx;
  logic [TIMEOUT_WIDTH-1:0] w_wd_inc;
  logic [ITER_WIDTH-1:0]    w_iter_inc;
  logic [ITER_WIDTH-1:0]    w_iter_tgt;
  logic                     w_p_last;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PHASES; gi++) begin : g_client
      assign w_cl_a[gi] = client_op_a[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_cl_b[gi] = client_op_b[gi*DATA_WIDTH +: DATA_WIDTH];
    end
    for (gi = 0; gi < NUM_INIT_VAL; gi++) begin : g_init
      assign init_val[gi*DATA_WIDTH +: DATA_WIDTH] = r_init[gi];
    end
  endgenerate

  assign w_p_inc    = r_p + 1'b1;
  assign w_fidx     = r_fcnt - 1'b1;
  assign w_wd_inc   = r_wd + 1'b1;
  assign w_p_last   = (r_p == PW'(NUM_PHASES - 1));
  // Saturating sweep counter; a requested count of 0 still runs one sweep.
  assign w_iter_inc = (r_iter == '1) ? r_iter : r_iter + 1'b1;
  assign w_iter_tgt = (r_num_iter == '0) ? ITER_WIDTH'(1) : r_num_iter;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_p           <= '0;
      r_fcnt        <= '0;
      r_wd          <= '0;
      r_tlim        <= '0;
      r_num_iter    <= '0;
      r_iter        <= '0;
      r_addr        <= '0;
      r_phase_start <= '0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      for (int k = 0; k < NUM_INIT_VAL; k++) r_init[k] <= '0;
    end else begin
      r_phase_start <= '0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      if (abort && r_state != S_IDLE) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (start) begin
            r_state    <= S_FETCH;
            r_iter     <= '0;
            r_p        <= '0;
            r_addr     <= '0;
            r_fcnt     <= '0;
            r_num_iter <= num_iter;
            r_tlim     <= timeout_limit;
          end
          // Cycle k of FETCH presents address k and captures the word addressed in cycle k-1.
          S_FETCH: begin
            if (r_fcnt != '0) r_init[w_fidx] <= mem_state_var_data_out;
            if (r_fcnt == FW'(NUM_INIT_VAL)) begin
              r_state       <= S_LAUNCH;
              r_phase_start <= NUM_PHASES'(1) << r_p;
            end else begin
              r_fcnt <= r_fcnt + 1'b1;
              if (r_fcnt < FW'(NUM_INIT_VAL - 1)) r_addr <= r_addr + 1'b1;
            end
          end
          S_LAUNCH: begin
            r_wd    <= '0;
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (phase_done[r_p]) begin
              r_state <= S_NEXT;
            end else begin
              r_wd <= w_wd_inc;
              if (r_tlim != '0 && w_wd_inc == r_tlim) begin
                r_state <= S_FAULT;
                r_error <= 1'b1;
              end
            end
          end
          S_NEXT: begin
            if (!w_p_last) begin
              r_p           <= w_p_inc;
              r_state       <= S_LAUNCH;
              r_phase_start <= NUM_PHASES'(1) << w_p_inc;
            end else begin
              r_iter <= w_iter_inc;
              r_p    <= '0;
              if (w_iter_inc < w_iter_tgt) begin
                r_state       <= S_LAUNCH;
                r_phase_start <= NUM_PHASES'(1);
              end else begin
                r_state <= S_FINISH;
                r_done  <= 1'b1;
              end
            end
          end
          S_FINISH: r_state <= S_IDLE;
          S_FAULT:  r_state <= S_IDLE;
          default:  r_state <= S_IDLE;
        endcase
      end
    end
  end

  // The operator unit belongs to the active phase only while that phase is launched or running.
  always_comb begin
    unit_op_a     = '0;
    unit_op_b     = '0;
    unit_op_start = 1'b0;
    if (r_state == S_LAUNCH || r_state == S_WAIT || r_state == S_NEXT) begin
      unit_op_a     = w_cl_a[r_p];
      unit_op_b     = w_cl_b[r_p];
      unit_op_start = client_op_start[r_p];
    end
  end

  assign phase_start        = abort ? '0 : r_phase_start;
  assign busy               = (r_state != S_IDLE);
  assign done               = r_done;
  assign error              = r_error;
  assign iter_count         = r_iter;
  assign mem_state_var_addr = r_addr;

endmodule

// File: tb/tb_state_var_sequencer.sv
// Randomized bench for state_var_sequencer: a per-run schedule model predicts every output cycle by cycle.
module tb_state_var_sequencer;
  localparam int DW = 32, NIV = 6, NP = 3, AW = 4, TW = 16, IW = 8, MAXC = 512;

  logic              clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
  logic [IW-1:0]     num_iter = '0;
  logic [TW-1:0]     timeout_limit = '0;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_data = '0;
  logic [NIV*DW-1:0] init_val;
  logic [NP-1:0]     phase_start, phase_done = '0, client_op_start = '0;
  logic [NP*DW-1:0]  client_op_a = '0, client_op_b = '0;
  logic [DW-1:0]     unit_op_a, unit_op_b;
  logic              unit_op_start, busy, done, error;
  logic [IW-1:0]     iter_count;

  logic [DW-1:0]     mem [2**AW];
  int n_checks = 0, n_fail = 0;
  int prev_iter = 0;

  // Expected per-cycle schedule of one run, indexed by cycles after the start request.
  int e_ps [MAXC], e_mux [MAXC], e_pd [MAXC], e_iter [MAXC];
  bit e_busy [MAXC], e_done [MAXC], e_err [MAXC];
  int e_end;

  state_var_sequencer #(
    .DATA_WIDTH(DW), .NUM_INIT_VAL(NIV), .NUM_PHASES(NP),
    .ADDR_WIDTH(AW), .TIMEOUT_WIDTH(TW), .ITER_WIDTH(IW)
  ) dut (
    .clock(clk), .reset(reset), .start(start), .abort(abort),
    .num_iter(num_iter), .timeout_limit(timeout_limit),
    .mem_state_var_addr(mem_addr), .mem_state_var_data_out(mem_data),
    .init_val(init_val), .phase_start(phase_start), .phase_done(phase_done),
    .client_op_a(client_op_a), .client_op_b(client_op_b), .client_op_start(client_op_start),
    .unit_op_a(unit_op_a), .unit_op_b(unit_op_b), .unit_op_start(unit_op_start),
    .busy(busy), .done(done), .error(error), .iter_count(iter_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mem_data <= mem[mem_addr];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic build_model(input int n_iter, input int tlim, input int stuck_it, input int stuck_p,
                             input int abort_mode, input int dmin, input int dmax, output int a_at);
    int iters, t, d, dm;
    int pd_list[$];
    bit stopped;
    for (int r = 0; r < MAXC; r++) begin
      e_ps[r] = -1; e_mux[r] = -1; e_pd[r] = -1;
      e_busy[r] = 0; e_done[r] = 0; e_err[r] = 0;
      e_iter[r] = (r == 0) ? prev_iter : 0;
    end
    iters   = (n_iter == 0) ? 1 : n_iter;
    dm      = (tlim > 0 && tlim < dmax) ? tlim : dmax;
    t       = NIV + 2;
    stopped = 0;
    for (int it = 0; it < iters && !stopped; it++) begin
      for (int p = 0; p < NP && !stopped; p++) begin
        e_ps[t] = p; e_mux[t] = p;
        if (it == stuck_it && p == stuck_p) begin
          for (int w = 1; w <= tlim; w++) e_mux[t+w] = p;
          e_err[t+1+tlim] = 1;
          e_end = t + 1 + tlim;
          stopped = 1;
        end else begin
          d = $urandom_range(dmin, dm);
          for (int w = 1; w <= d; w++) e_mux[t+w] = p;
          e_pd[t+d] = p;
          pd_list.push_back(t + d);
          e_mux[t+d+1] = p;
          if (p == NP - 1)
            for (int r = t + d + 2; r < MAXC; r++) e_iter[r] = it + 1;
          t = t + d + 2;
        end
      end
    end
    if (!stopped) begin
      e_done[t] = 1;
      e_end = t;
    end
    for (int r = 1; r <= e_end; r++) e_busy[r] = 1;
    a_at = -1;
    if (abort_mode == 1 && pd_list.size() > 0) a_at = pd_list[$urandom_range(0, pd_list.size() - 1)];
    if (abort_mode == 2) a_at = $urandom_range(1, e_end - 1);
    if (a_at > 0) begin
      e_ps[a_at] = -1;
      for (int r = a_at + 1; r < MAXC; r++) begin
        e_ps[r] = -1; e_mux[r] = -1; e_pd[r] = -1;
        e_busy[r] = 0; e_done[r] = 0; e_err[r] = 0;
        e_iter[r] = e_iter[a_at];
      end
      e_end = a_at;
    end
  endtask

  task automatic step(input int r, input int n_iter, input int tlim, input int a_at);
    logic [NP-1:0] pd;
    logic [DW-1:0] ea, eb;
    logic          es;
    @(negedge clk);
    start         = (r == 0) ? 1'b1 : ((r <= e_end) ? 1'($urandom_range(0, 1)) : 1'b0);
    abort         = (r == a_at);
    num_iter      = (r == 0) ? IW'(n_iter) : IW'($urandom);
    timeout_limit = (r == 0) ? TW'(tlim) : TW'($urandom);
    pd = NP'($urandom);
    if (e_mux[r] >= 0) pd[e_mux[r]] = 1'b0;
    if (e_pd[r] >= 0) pd[e_pd[r]] = 1'b1;
    phase_done      = pd;
    client_op_a     = {$urandom, $urandom, $urandom};
    client_op_b     = {$urandom, $urandom, $urandom};
    client_op_start = NP'($urandom);
    #1;
    ea = '0; eb = '0; es = 1'b0;
    if (e_mux[r] >= 0) begin
      ea = client_op_a[e_mux[r]*DW +: DW];
      eb = client_op_b[e_mux[r]*DW +: DW];
      es = client_op_start[e_mux[r]];
    end
    check_eq("phase_start", phase_start, (e_ps[r] < 0) ? 64'd0 : (64'd1 << e_ps[r]));
    check_eq("busy", busy, e_busy[r]);
    check_eq("done", done, e_done[r]);
    check_eq("error", error, e_err[r]);
    check_eq("iter_count", iter_count, e_iter[r]);
    check_eq("unit_op_a", unit_op_a, ea);
    check_eq("unit_op_b", unit_op_b, eb);
    check_eq("unit_op_start", unit_op_start, es);
    if (r >= 1 && r <= NIV && r <= e_end) check_eq("fetch_addr", mem_addr, r - 1);
  endtask

  task automatic run(input int n_iter, input int tlim, input int stuck_it, input int stuck_p,
                     input int abort_mode, input int dmin, input int dmax, input bit seq_mem);
    int a_at;
    logic [DW-1:0] words [NIV];
    for (int k = 0; k < NIV; k++) begin
      words[k] = seq_mem ? DW'(100 + k) : $urandom;
      mem[k]   = words[k];
    end
    build_model(n_iter, tlim, stuck_it, stuck_p, abort_mode, dmin, dmax, a_at);
    for (int r = 0; r <= e_end + 2; r++) step(r, n_iter, tlim, a_at);
    if (a_at < 0 || a_at > NIV + 1)
      for (int k = 0; k < NIV; k++) check_eq("init_val", init_val[k*DW +: DW], words[k]);
    prev_iter = e_iter[e_end + 1];
    $display("run num_iter=%0d tlim=%0d stuck=%0d/%0d abort_at=%0d end=%0d iter=%0d",
             n_iter, tlim, stuck_it, stuck_p, a_at, e_end, prev_iter);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_error"}, error, 0);
    check_eq({tag, "_phase_start"}, phase_start, 0);
    check_eq({tag, "_iter"}, iter_count, 0);
    check_eq({tag, "_addr"}, mem_addr, 0);
    check_eq({tag, "_unit"}, {unit_op_start, unit_op_a}, 0);
    for (int k = 0; k < NIV; k++) check_eq({tag, "_init"}, init_val[k*DW +: DW], 0);
  endtask

  initial begin
    int a_dummy, ni, tl, st_it, st_p, am;
    for (int k = 0; k < 2**AW; k++) mem[k] = $urandom;
    #2 reset = 1'b1;
    #1 check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    run(1, 0, -1, -1, 0, 2, 2, 1'b1);   // basic sweep, fixed 2-cycle phases
    run(0, 0, -1, -1, 0, 2, 2, 1'b1);   // zero iterations behaves as one
    run(3, 0, -1, -1, 0, 1, 5, 1'b0);   // three sweeps, single fetch
    run(1, 5, 0, 1, 0, 1, 5, 1'b0);     // phase 1 never completes
    run(2, 0, -1, -1, 1, 1, 4, 1'b0);   // abort together with phase_done

    // Reset in the middle of a WAIT, then a normal run.
    for (int k = 0; k < NIV; k++) mem[k] = $urandom;
    build_model(1, 0, -1, -1, 0, 4, 4, a_dummy);
    for (int r = 0; r <= NIV + 4; r++) step(r, 1, 0, -1);
    #1 reset = 1'b1;
    #1 check_all_zero("midrun_reset");
    @(negedge clk);
    reset = 1'b0; start = 1'b0; abort = 1'b0; phase_done = '0;
    prev_iter = 0;
    $display("reset asserted during WAIT of phase 0");
    run(2, 0, -1, -1, 0, 1, 3, 1'b0);

    for (int i = 0; i < 20; i++) begin
      ni    = $urandom_range(0, 3);
      tl    = ($urandom_range(0, 1) == 1) ? $urandom_range(3, 8) : 0;
      st_it = -1; st_p = -1; am = 0;
      if (tl > 0 && $urandom_range(0, 3) == 0) begin
        st_it = $urandom_range(0, (ni == 0) ? 0 : ni - 1);
        st_p  = $urandom_range(0, NP - 1);
      end else if ($urandom_range(0, 4) == 0) begin
        am = $urandom_range(1, 2);
      end
      run(ni, tl, st_it, st_p, am, 1, 6, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
